ad1_sample_scheduler: RTL

Sequencing and buffering controller for the dual-channel PmodAD1 SPI core. It gates the SPI core on and off through that core's reset, detects each completed conversion from the core's data-ready flag, and averages 2^AVG_LOG2 conversions per channel. Each averaged channel pair is then queued in a small first-word-fall-through FIFO with a valid/ready output. It sits between the SPI core and the AXI/register or stream logic of the PmodAD1 IP.

---
 rtl/ad1_sample_scheduler.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ad1_sample_scheduler.sv
// PmodAD1 sample scheduler: gates the SPI core, averages 2^AVG_LOG2 conversions per channel
// and queues results in a FWFT FIFO. Define AD1_SCHED_TIMESTAMP_EN to add the m_time output.
module ad1_sample_scheduler #(
   parameter int AVG_LOG2        = 2,
   parameter int FIFO_DEPTH_LOG2 = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   output logic        spi_rst,
   input  logic        drdy,
   input  logic [15:0] din0,
   input  logic [15:0] din1,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [11:0] m_data0,
   output logic [11:0] m_data1,
   output logic        overflow,
`ifdef AD1_SCHED_TIMESTAMP_EN
   output logic [31:0] m_time,
`endif
   input  logic        clear_ovf
);

   localparam int ACC_W = 12 + AVG_LOG2;
   localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int PW    = FIFO_DEPTH_LOG2;
   localparam int CW    = FIFO_DEPTH_LOG2 + 1;
`ifdef AD1_SCHED_TIMESTAMP_EN
   localparam int E_W   = 56;
`else
   localparam int E_W   = 24;
`endif
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [CW-1:0]    FIFO_FULL = CW'(DEPTH);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t           state_r, state_nx_s;
   logic             spi_rst_r, drdy_q_r, ev_s;
   logic [ACC_W-1:0] acc0_r, acc1_r, sum0_s, sum1_s;
   logic [CNT_W-1:0] cnt_r;
   logic [11:0]      avg0_s, avg1_s;
   logic [E_W-1:0]   entry_s, push_data_r, head_r, head_nx_s;
   logic             push_pend_r;
   logic [E_W-1:0]   mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r, rd_ptr_r, rd_nx_s;
   logic [CW-1:0]    count_r, count_nx_s;
   logic             m_valid_r, overflow_r;
   logic             fifo_full_s, pop_s, wr_s, drop_s;
   logic             unused_hi_s;
`ifdef AD1_SCHED_TIMESTAMP_EN
   logic [31:0]      ts_r;
`endif

   assign unused_hi_s = ^{din0[15:12], din1[15:12]};

   // Next state and conversion-event detection; an event in a cycle with enable low is ignored
   always_comb begin
      state_nx_s = state_r;
      ev_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (enable) state_nx_s = ST_RUN;
            else        state_nx_s = ST_IDLE;
         end
         ST_RUN: begin
            if (enable) begin
               state_nx_s = ST_RUN;
               ev_s       = drdy & ~drdy_q_r;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // State register, registered core gate and drdy edge history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         spi_rst_r <= 1'b1;
         drdy_q_r  <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         spi_rst_r <= (state_nx_s == ST_IDLE);
         drdy_q_r  <= drdy;
      end
   end

   assign sum0_s = acc0_r + ACC_W'(din0[11:0]);
   assign sum1_s = acc1_r + ACC_W'(din1[11:0]);
   assign avg0_s = 12'(sum0_s >> AVG_LOG2);
   assign avg1_s = 12'(sum1_s >> AVG_LOG2);

   // Assemble a FIFO entry from the completing averages
   always_comb begin
`ifdef AD1_SCHED_TIMESTAMP_EN
      entry_s = {ts_r, avg1_s, avg0_s};
`else
      entry_s = {avg1_s, avg0_s};
`endif
   end

   // Accumulators and the one-entry push register; push_pend lives exactly one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc0_r      <= {ACC_W{1'b0}};
         acc1_r      <= {ACC_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         push_pend_r <= 1'b0;
         push_data_r <= {E_W{1'b0}};
      end else if (state_r != ST_RUN || !enable) begin
         acc0_r      <= {ACC_W{1'b0}};
         acc1_r      <= {ACC_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         push_pend_r <= 1'b0;
      end else if (ev_s && cnt_r == CNT_LAST) begin
         acc0_r      <= {ACC_W{1'b0}};
         acc1_r      <= {ACC_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         push_pend_r <= 1'b1;
         push_data_r <= entry_s;
      end else if (ev_s) begin
         acc0_r      <= sum0_s;
         acc1_r      <= sum1_s;
         cnt_r       <= cnt_r + CNT_W'(1);
         push_pend_r <= 1'b0;
      end else begin
         push_pend_r <= 1'b0;
      end
   end

`ifdef AD1_SCHED_TIMESTAMP_EN
   // Free-running cycle counter sampled into each entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ts_r <= 32'd0;
      else     ts_r <= ts_r + 32'd1;
   end
`endif

   assign fifo_full_s = (count_r == FIFO_FULL);
   assign pop_s       = m_valid_r & m_ready;
   assign wr_s        = push_pend_r & (~fifo_full_s | pop_s);
   assign drop_s      = push_pend_r & fifo_full_s & ~pop_s;

   // Next read pointer, occupancy and the entry that will sit at the head
   always_comb begin
      rd_nx_s    = rd_ptr_r;
      count_nx_s = count_r;
      head_nx_s  = head_r;
      if (pop_s) rd_nx_s = rd_ptr_r + PW'(1);
      else       rd_nx_s = rd_ptr_r;
      case ({wr_s, pop_s})
         2'b10:   count_nx_s = count_r + CW'(1);
         2'b01:   count_nx_s = count_r - CW'(1);
         default: count_nx_s = count_r;
      endcase
      // The head slot may be the one being written this very cycle
      if (wr_s && rd_nx_s == wr_ptr_r) head_nx_s = push_data_r;
      else                             head_nx_s = mem_r[rd_nx_s];
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (wr_s) mem_r[wr_ptr_r] <= push_data_r;
   end

   // FIFO pointers, registered head/valid and the sticky overflow flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r   <= {PW{1'b0}};
         rd_ptr_r   <= {PW{1'b0}};
         count_r    <= {CW{1'b0}};
         m_valid_r  <= 1'b0;
         head_r     <= {E_W{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         if (wr_s) wr_ptr_r <= wr_ptr_r + PW'(1);
         rd_ptr_r  <= rd_nx_s;
         count_r   <= count_nx_s;
         m_valid_r <= (count_nx_s != {CW{1'b0}});
         if (count_nx_s != {CW{1'b0}}) head_r <= head_nx_s;
         if (drop_s)         overflow_r <= 1'b1;
         else if (clear_ovf) overflow_r <= 1'b0;
      end
   end

   assign spi_rst  = spi_rst_r;
   assign m_valid  = m_valid_r;
   assign m_data0  = head_r[11:0];
   assign m_data1  = head_r[23:12];
   assign overflow = overflow_r;
`ifdef AD1_SCHED_TIMESTAMP_EN
   assign m_time   = head_r[55:24];
`endif

endmodule
